// File: rtl/engine_inv_round_transformer_pkg.sv
// Shared AES-128 decrypt definitions: FSM encodings, round count and GF(2^8) helpers (poly 0x11B).
// The gf_mul* helpers build the InvMixColumns coefficients from a single xtime chain.
package engine_inv_round_transformer_pkg;

   localparam int AES128_ROUNDS = 10;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARK   = 3'd1,
      S_ROUND = 3'd2,
      S_FINAL = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul09(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ b;
   endfunction

   function automatic logic [7:0] gf_mul0b(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x2 ^ b;
   endfunction

   function automatic logic [7:0] gf_mul0d(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ b;
   endfunction

   function automatic logic [7:0] gf_mul0e(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out, zero latency.
// No handshake; purely a lookup used by the round datapath.
module aes_inv_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   always_comb begin
      o_byte = 8'h00;
      case (i_byte)
         8'h00: o_byte = 8'h52; 8'h01: o_byte = 8'h09; 8'h02: o_byte = 8'h6a; 8'h03: o_byte = 8'hd5; 8'h04: o_byte = 8'h30; 8'h05: o_byte = 8'h36; 8'h06: o_byte = 8'ha5; 8'h07: o_byte = 8'h38;
         8'h08: o_byte = 8'hbf; 8'h09: o_byte = 8'h40; 8'h0a: o_byte = 8'ha3; 8'h0b: o_byte = 8'h9e; 8'h0c: o_byte = 8'h81; 8'h0d: o_byte = 8'hf3; 8'h0e: o_byte = 8'hd7; 8'h0f: o_byte = 8'hfb;
         8'h10: o_byte = 8'h7c; 8'h11: o_byte = 8'he3; 8'h12: o_byte = 8'h39; 8'h13: o_byte = 8'h82; 8'h14: o_byte = 8'h9b; 8'h15: o_byte = 8'h2f; 8'h16: o_byte = 8'hff; 8'h17: o_byte = 8'h87;
         8'h18: o_byte = 8'h34; 8'h19: o_byte = 8'h8e; 8'h1a: o_byte = 8'h43; 8'h1b: o_byte = 8'h44; 8'h1c: o_byte = 8'hc4; 8'h1d: o_byte = 8'hde; 8'h1e: o_byte = 8'he9; 8'h1f: o_byte = 8'hcb;
         8'h20: o_byte = 8'h54; 8'h21: o_byte = 8'h7b; 8'h22: o_byte = 8'h94; 8'h23: o_byte = 8'h32; 8'h24: o_byte = 8'ha6; 8'h25: o_byte = 8'hc2; 8'h26: o_byte = 8'h23; 8'h27: o_byte = 8'h3d;
         8'h28: o_byte = 8'hee; 8'h29: o_byte = 8'h4c; 8'h2a: o_byte = 8'h95; 8'h2b: o_byte = 8'h0b; 8'h2c: o_byte = 8'h42; 8'h2d: o_byte = 8'hfa; 8'h2e: o_byte = 8'hc3; 8'h2f: o_byte = 8'h4e;
         8'h30: o_byte = 8'h08; 8'h31: o_byte = 8'h2e; 8'h32: o_byte = 8'ha1; 8'h33: o_byte = 8'h66; 8'h34: o_byte = 8'h28; 8'h35: o_byte = 8'hd9; 8'h36: o_byte = 8'h24; 8'h37: o_byte = 8'hb2;
         8'h38: o_byte = 8'h76; 8'h39: o_byte = 8'h5b; 8'h3a: o_byte = 8'ha2; 8'h3b: o_byte = 8'h49; 8'h3c: o_byte = 8'h6d; 8'h3d: o_byte = 8'h8b; 8'h3e: o_byte = 8'hd1; 8'h3f: o_byte = 8'h25;
         8'h40: o_byte = 8'h72; 8'h41: o_byte = 8'hf8; 8'h42: o_byte = 8'hf6; 8'h43: o_byte = 8'h64; 8'h44: o_byte = 8'h86; 8'h45: o_byte = 8'h68; 8'h46: o_byte = 8'h98; 8'h47: o_byte = 8'h16;
         8'h48: o_byte = 8'hd4; 8'h49: o_byte = 8'ha4; 8'h4a: o_byte = 8'h5c; 8'h4b: o_byte = 8'hcc; 8'h4c: o_byte = 8'h5d; 8'h4d: o_byte = 8'h65; 8'h4e: o_byte = 8'hb6; 8'h4f: o_byte = 8'h92;
         8'h50: o_byte = 8'h6c; 8'h51: o_byte = 8'h70; 8'h52: o_byte = 8'h48; 8'h53: o_byte = 8'h50; 8'h54: o_byte = 8'hfd; 8'h55: o_byte = 8'hed; 8'h56: o_byte = 8'hb9; 8'h57: o_byte = 8'hda;
         8'h58: o_byte = 8'h5e; 8'h59: o_byte = 8'h15; 8'h5a: o_byte = 8'h46; 8'h5b: o_byte = 8'h57; 8'h5c: o_byte = 8'ha7; 8'h5d: o_byte = 8'h8d; 8'h5e: o_byte = 8'h9d; 8'h5f: o_byte = 8'h84;
         8'h60: o_byte = 8'h90; 8'h61: o_byte = 8'hd8; 8'h62: o_byte = 8'hab; 8'h63: o_byte = 8'h00; 8'h64: o_byte = 8'h8c; 8'h65: o_byte = 8'hbc; 8'h66: o_byte = 8'hd3; 8'h67: o_byte = 8'h0a;
         8'h68: o_byte = 8'hf7; 8'h69: o_byte = 8'he4; 8'h6a: o_byte = 8'h58; 8'h6b: o_byte = 8'h05; 8'h6c: o_byte = 8'hb8; 8'h6d: o_byte = 8'hb3; 8'h6e: o_byte = 8'h45; 8'h6f: o_byte = 8'h06;
         8'h70: o_byte = 8'hd0; 8'h71: o_byte = 8'h2c; 8'h72: o_byte = 8'h1e; 8'h73: o_byte = 8'h8f; 8'h74: o_byte = 8'hca; 8'h75: o_byte = 8'h3f; 8'h76: o_byte = 8'h0f; 8'h77: o_byte = 8'h02;
         8'h78: o_byte = 8'hc1; 8'h79: o_byte = 8'haf; 8'h7a: o_byte = 8'hbd; 8'h7b: o_byte = 8'h03; 8'h7c: o_byte = 8'h01; 8'h7d: o_byte = 8'h13; 8'h7e: o_byte = 8'h8a; 8'h7f: o_byte = 8'h6b;
         8'h80: o_byte = 8'h3a; 8'h81: o_byte = 8'h91; 8'h82: o_byte = 8'h11; 8'h83: o_byte = 8'h41; 8'h84: o_byte = 8'h4f; 8'h85: o_byte = 8'h67; 8'h86: o_byte = 8'hdc; 8'h87: o_byte = 8'hea;
         8'h88: o_byte = 8'h97; 8'h89: o_byte = 8'hf2; 8'h8a: o_byte = 8'hcf; 8'h8b: o_byte = 8'hce; 8'h8c: o_byte = 8'hf0; 8'h8d: o_byte = 8'hb4; 8'h8e: o_byte = 8'he6; 8'h8f: o_byte = 8'h73;
         8'h90: o_byte = 8'h96; 8'h91: o_byte = 8'hac; 8'h92: o_byte = 8'h74; 8'h93: o_byte = 8'h22; 8'h94: o_byte = 8'he7; 8'h95: o_byte = 8'had; 8'h96: o_byte = 8'h35; 8'h97: o_byte = 8'h85;
         8'h98: o_byte = 8'he2; 8'h99: o_byte = 8'hf9; 8'h9a: o_byte = 8'h37; 8'h9b: o_byte = 8'he8; 8'h9c: o_byte = 8'h1c; 8'h9d: o_byte = 8'h75; 8'h9e: o_byte = 8'hdf; 8'h9f: o_byte = 8'h6e;
         8'ha0: o_byte = 8'h47; 8'ha1: o_byte = 8'hf1; 8'ha2: o_byte = 8'h1a; 8'ha3: o_byte = 8'h71; 8'ha4: o_byte = 8'h1d; 8'ha5: o_byte = 8'h29; 8'ha6: o_byte = 8'hc5; 8'ha7: o_byte = 8'h89;
         8'ha8: o_byte = 8'h6f; 8'ha9: o_byte = 8'hb7; 8'haa: o_byte = 8'h62; 8'hab: o_byte = 8'h0e; 8'hac: o_byte = 8'haa; 8'had: o_byte = 8'h18; 8'hae: o_byte = 8'hbe; 8'haf: o_byte = 8'h1b;
         8'hb0: o_byte = 8'hfc; 8'hb1: o_byte = 8'h56; 8'hb2: o_byte = 8'h3e; 8'hb3: o_byte = 8'h4b; 8'hb4: o_byte = 8'hc6; 8'hb5: o_byte = 8'hd2; 8'hb6: o_byte = 8'h79; 8'hb7: o_byte = 8'h20;
         8'hb8: o_byte = 8'h9a; 8'hb9: o_byte = 8'hdb; 8'hba: o_byte = 8'hc0; 8'hbb: o_byte = 8'hfe; 8'hbc: o_byte = 8'h78; 8'hbd: o_byte = 8'hcd; 8'hbe: o_byte = 8'h5a; 8'hbf: o_byte = 8'hf4;
         8'hc0: o_byte = 8'h1f; 8'hc1: o_byte = 8'hdd; 8'hc2: o_byte = 8'ha8; 8'hc3: o_byte = 8'h33; 8'hc4: o_byte = 8'h88; 8'hc5: o_byte = 8'h07; 8'hc6: o_byte = 8'hc7; 8'hc7: o_byte = 8'h31;
         8'hc8: o_byte = 8'hb1; 8'hc9: o_byte = 8'h12; 8'hca: o_byte = 8'h10; 8'hcb: o_byte = 8'h59; 8'hcc: o_byte = 8'h27; 8'hcd: o_byte = 8'h80; 8'hce: o_byte = 8'hec; 8'hcf: o_byte = 8'h5f;
         8'hd0: o_byte = 8'h60; 8'hd1: o_byte = 8'h51; 8'hd2: o_byte = 8'h7f; 8'hd3: o_byte = 8'ha9; 8'hd4: o_byte = 8'h19; 8'hd5: o_byte = 8'hb5; 8'hd6: o_byte = 8'h4a; 8'hd7: o_byte = 8'h0d;
         8'hd8: o_byte = 8'h2d; 8'hd9: o_byte = 8'he5; 8'hda: o_byte = 8'h7a; 8'hdb: o_byte = 8'h9f; 8'hdc: o_byte = 8'h93; 8'hdd: o_byte = 8'hc9; 8'hde: o_byte = 8'h9c; 8'hdf: o_byte = 8'hef;
         8'he0: o_byte = 8'ha0; 8'he1: o_byte = 8'he0; 8'he2: o_byte = 8'h3b; 8'he3: o_byte = 8'h4d; 8'he4: o_byte = 8'hae; 8'he5: o_byte = 8'h2a; 8'he6: o_byte = 8'hf5; 8'he7: o_byte = 8'hb0;
         8'he8: o_byte = 8'hc8; 8'he9: o_byte = 8'heb; 8'hea: o_byte = 8'hbb; 8'heb: o_byte = 8'h3c; 8'hec: o_byte = 8'h83; 8'hed: o_byte = 8'h53; 8'hee: o_byte = 8'h99; 8'hef: o_byte = 8'h61;
         8'hf0: o_byte = 8'h17; 8'hf1: o_byte = 8'h2b; 8'hf2: o_byte = 8'h04; 8'hf3: o_byte = 8'h7e; 8'hf4: o_byte = 8'hba; 8'hf5: o_byte = 8'h77; 8'hf6: o_byte = 8'hd6; 8'hf7: o_byte = 8'h26;
         8'hf8: o_byte = 8'he1; 8'hf9: o_byte = 8'h69; 8'hfa: o_byte = 8'h14; 8'hfb: o_byte = 8'h63; 8'hfc: o_byte = 8'h55; 8'hfd: o_byte = 8'h21; 8'hfe: o_byte = 8'h0c; 8'hff: o_byte = 8'h7d;
         default: o_byte = 8'h00;
      endcase
   end

endmodule

// File: rtl/engine_inv_round_transformer.sv
// Iterative AES-128 InvCipher, one inverse round per clock; done rises 11 clocks after an accepted start.
// Start is only accepted in IDLE; done is a level held until output_read, with no queueing behind it.
module engine_inv_round_transformer
   import engine_inv_round_transformer_pkg::*;
#(
   parameter int ROUNDS = AES128_ROUNDS
) (
   input  logic         clk,
   input  logic         rst_,
   input  logic [127:0] ciphertext,
   input  logic         transformer_start,
   input  logic         output_read,
   input  logic [127:0] round0_key,
   input  logic [127:0] round1_key,
   input  logic [127:0] round2_key,
   input  logic [127:0] round3_key,
   input  logic [127:0] round4_key,
   input  logic [127:0] round5_key,
   input  logic [127:0] round6_key,
   input  logic [127:0] round7_key,
   input  logic [127:0] round8_key,
   input  logic [127:0] round9_key,
   input  logic [127:0] round10_key,
   output logic [127:0] plaintext,
   output logic         transformer_done
);

   if (ROUNDS != AES128_ROUNDS) begin : g_rounds_check
      $error("engine_inv_round_transformer supports only ROUNDS = 10 (AES-128)");
   end

   state_t       r_state;
   state_t       w_state_nxt;
   logic [127:0] r_st;
   logic [3:0]   r_rnd;
   logic [127:0] r_plaintext;
   logic         r_done;
   logic [127:0] w_shift;
   logic [127:0] w_sub;
   logic [127:0] w_rkey;
   logic [127:0] w_ark;
   logic [127:0] w_mix;

   // Byte n lives at bits [127-8n -: 8]; row r, column c is byte r+4c.
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gf_mul0e(a0) ^ gf_mul0b(a1) ^ gf_mul0d(a2) ^ gf_mul09(a3);
         o[119-32*c -: 8] = gf_mul09(a0) ^ gf_mul0e(a1) ^ gf_mul0b(a2) ^ gf_mul0d(a3);
         o[111-32*c -: 8] = gf_mul0d(a0) ^ gf_mul09(a1) ^ gf_mul0e(a2) ^ gf_mul0b(a3);
         o[103-32*c -: 8] = gf_mul0b(a0) ^ gf_mul0d(a1) ^ gf_mul09(a2) ^ gf_mul0e(a3);
      end
      return o;
   endfunction

   assign w_shift = inv_shift_rows(r_st);

   for (genvar g = 0; g < 16; g++) begin : g_sbox
      aes_inv_sbox u_inv_sbox (
         .i_byte (w_shift[127-8*g -: 8]),
         .o_byte (w_sub[127-8*g -: 8])
      );
   end

   always_comb begin
      w_rkey = '0;
      case (r_rnd)
         4'd0:    w_rkey = round0_key;
         4'd1:    w_rkey = round1_key;
         4'd2:    w_rkey = round2_key;
         4'd3:    w_rkey = round3_key;
         4'd4:    w_rkey = round4_key;
         4'd5:    w_rkey = round5_key;
         4'd6:    w_rkey = round6_key;
         4'd7:    w_rkey = round7_key;
         4'd8:    w_rkey = round8_key;
         4'd9:    w_rkey = round9_key;
         4'd10:   w_rkey = round10_key;
         default: w_rkey = '0;
      endcase
   end

   // In FINAL the counter sits at 0, so the same AddRoundKey path yields the plaintext.
   assign w_ark = w_sub ^ w_rkey;
   assign w_mix = inv_mix_columns(w_ark);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (transformer_start) w_state_nxt = S_ARK;
         S_ARK:   w_state_nxt = S_ROUND;
         S_ROUND: if (r_rnd == 4'd1) w_state_nxt = S_FINAL;
         S_FINAL: w_state_nxt = S_DONE;
         S_DONE:  if (output_read) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_st        <= '0;
         r_rnd       <= '0;
         r_plaintext <= '0;
         r_done      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (transformer_start) r_st <= ciphertext;
            end
            S_ARK: begin
               r_st  <= r_st ^ round10_key;
               r_rnd <= 4'd9;
            end
            S_ROUND: begin
               r_st  <= w_mix;
               r_rnd <= r_rnd - 4'd1;
            end
            S_FINAL: begin
               r_plaintext <= w_ark;
               r_done      <= 1'b1;
            end
            S_DONE: begin
               if (output_read) r_done <= 1'b0;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign plaintext        = r_plaintext;
   assign transformer_done = r_done;

endmodule

// File: tb/tb_engine_inv_round_transformer.sv
// Scoreboard bench for the AES-128 inverse round transformer using FIPS-197 C.1 and App.B vectors.
module tb_engine_inv_round_transformer;

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   localparam logic [127:0] SBOX_ROW [0:15] = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef struct {
      logic [127:0] pt;
      int           cyc;
   } exp_t;

   logic         clk;
   logic         rst_;
   logic [127:0] ciphertext;
   logic         transformer_start;
   logic         output_read;
   logic [127:0] rk [0:10];
   logic [127:0] plaintext;
   logic         transformer_done;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   engine_inv_round_transformer dut (
      .clk               (clk),
      .rst_              (rst_),
      .ciphertext        (ciphertext),
      .transformer_start (transformer_start),
      .output_read       (output_read),
      .round0_key        (rk[0]),
      .round1_key        (rk[1]),
      .round2_key        (rk[2]),
      .round3_key        (rk[3]),
      .round4_key        (rk[4]),
      .round5_key        (rk[5]),
      .round6_key        (rk[6]),
      .round7_key        (rk[7]),
      .round8_key        (rk[8]),
      .round9_key        (rk[9]),
      .round10_key       (rk[10]),
      .plaintext         (plaintext),
      .transformer_done  (transformer_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] sb(input logic [7:0] b);
      logic [127:0] row;
      row = SBOX_ROW[b[7:4]];
      return row[8*(15-int'(b[3:0])) +: 8];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   task automatic load_keys(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sb(t[23:16]), sb(t[15:8]), sb(t[7:0]), sb(t[31:24])} ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   // Called at a negedge; the start is taken at the following posedge.
   task automatic do_start(input logic [127:0] ct, input logic [127:0] pt);
      exp_t e;
      ciphertext        = ct;
      transformer_start = 1'b1;
      e.pt  = pt;
      e.cyc = cyc + 1 + 11;
      exp_q.push_back(e);
      @(negedge clk);
      transformer_start = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      while (!transformer_done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!transformer_done) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: done=%0b after %0d cycles, expected 1", nm, transformer_done, n);
      end
   endtask

   task automatic read_pulse();
      output_read = 1'b1;
      @(negedge clk);
      output_read = 1'b0;
   endtask

   // Monitor: every rising edge of done must match the oldest outstanding expectation.
   initial begin
      logic prev_done;
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (transformer_done && !prev_done) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_done: done rose at cycle %0d with no result outstanding", cyc);
            end else begin
               e = exp_q.pop_front();
               check("sb_plaintext", plaintext, e.pt);
               check("sb_latency", 128'(cyc), 128'(e.cyc));
            end
         end
         prev_done = transformer_done;
      end
   end

   initial begin
      #50000;
      $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      rst_              = 1'b0;
      ciphertext        = '0;
      transformer_start = 1'b0;
      output_read       = 1'b0;
      load_keys(C1_KEY);
      repeat (3) @(negedge clk);
      check("reset_done", 128'(transformer_done), 128'(0));
      check("reset_plaintext", plaintext, '0);
      rst_ = 1'b1;
      @(negedge clk);

      // C.1 with ignored start pulses at cycles 3 and 10 carrying another ciphertext.
      do_start(C1_CT, C1_PT);
      for (int i = 1; i <= 10; i++) begin
         transformer_start = (i == 3 || i == 10);
         ciphertext        = (i == 3 || i == 10) ? B_CT : C1_CT;
         @(negedge clk);
      end
      transformer_start = 1'b0;
      wait_done("c1");

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("hold_done", 128'(transformer_done), 128'(1));
         check("hold_plaintext", plaintext, C1_PT);
      end

      // Read and start together in DONE: read wins, start is dropped.
      ciphertext        = B_CT;
      transformer_start = 1'b1;
      read_pulse();
      transformer_start = 1'b0;
      check("read_release", 128'(transformer_done), 128'(0));
      check("plaintext_retained", plaintext, C1_PT);
      repeat (14) @(negedge clk);
      check("dropped_start_idle", 128'(transformer_done), 128'(0));

      // App.B, read in the first DONE cycle, then an immediate C.1 start.
      load_keys(B_KEY);
      do_start(B_CT, B_PT);
      wait_done("appb");
      read_pulse();
      check("single_cycle_done", 128'(transformer_done), 128'(0));
      load_keys(C1_KEY);
      do_start(C1_CT, C1_PT);
      wait_done("b2b");
      read_pulse();
      check("b2b_release", 128'(transformer_done), 128'(0));

      // Reset five cycles into a decrypt, then a fresh App.B run.
      do_start(C1_CT, C1_PT);
      repeat (4) @(negedge clk);
      rst_ = 1'b0;
      #1;
      check("midrst_done", 128'(transformer_done), 128'(0));
      check("midrst_plaintext", plaintext, '0);
      exp_q.delete();
      @(negedge clk);
      rst_ = 1'b1;
      load_keys(B_KEY);
      do_start(B_CT, B_PT);
      wait_done("post_reset");
      read_pulse();

      repeat (14) @(negedge clk);
      check("outstanding_results", 128'(exp_q.size()), 128'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
